btn_event_encoder: RTL and testbench
====================================

Name: btn_event_encoder

Overview:
- Sits directly downstream of the debounced switch/button array and consumes its N debounced levels.
- Per channel, produces one-cycle press and release pulses and a long-press detection.
- All events are serialised into a small FIFO, with a valid/ready output for the control/command logic of the detector firmware.

Parameters:
- N, 4, number of debounced input channels.
- LONG_PRESS_CYC, 100_000_000, hold duration in clk cycles (1 s at 100 MHz) that qualifies as a long press; must be >= 2.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of two and >= 2.
- IDW, $clog2(N) (min 1), width of the channel id field (derived).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- db_in  in  N  debounced levels; 1 = pressed.
- press_pulse  out  N  one-cycle pulse per channel on a 0->1 transition.
- release_pulse  out  N  one-cycle pulse per channel on a 1->0 transition.
- ev_valid  out  1  FIFO head holds a valid event.
- ev_ready  in  1  consumer accepts the head event when ev_valid && ev_ready.
- ev_id  out  IDW  channel index of the head event.
- ev_type  out  2  head event type: 00 press, 01 long, 10 release (11 unused).
- overflow  out  1  sticky flag: an event was dropped.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values:
  - press_pulse = 0, release_pulse = 0, ev_valid = 0, overflow = 0.
  - ev_id and ev_type = 0.
  - FIFO empty; all pending bits and hold counters cleared; prev = 0; armed = 0.
- Arming:
  - The first edge after reset deasserts loads prev <= db_in and sets armed = 1, with no events.
  - Inputs already high out of reset never produce a press event.
- Edge detect when armed:
  - rise[i] = db_in[i] & ~prev[i]; fall[i] = ~db_in[i] & prev[i].
  - Pulses are registered: press_pulse[i] is high for exactly the one cycle after the edge that first samples db_in[i] = 1 (release_pulse likewise for 0).
- Hold counter per channel:
  - Clears on rise; increments while db_in[i] = 1.
  - When it reaches LONG_PRESS_CYC-1, raise a long event once, then saturate (no repeat).
  - Clears on fall. A release before the threshold produces no long event.
- Pending bits: three per channel (press, long, release), set by the corresponding event.
- Arbiter:
  - Each cycle, if the FIFO is not full, push exactly one event.
  - Pick the lowest channel index with any pending bit; within that channel the order is press, then long, then release.
  - Clear the pushed pending bit on the same edge.
- Collisions:
  - Event set on a bit that is being pushed the same cycle: the set wins, no loss.
  - Event set on a bit already pending and not pushed: the event is dropped and overflow <= 1.
- Overflow flag:
  - Stays set until clear_overflow; clear_overflow is ignored on a cycle that also detects a new drop (set wins).
- Latency, empty FIFO and no contention: ev_valid rises one cycle after the corresponding press_pulse/release_pulse cycle.
- FIFO:
  - First-word fall-through; ev_valid = !empty; ev_id and ev_type are stable while ev_valid && !ev_ready.
  - Pop on ev_valid && ev_ready.
  - Push and pop in the same cycle are both allowed when not full.
  - When full, no push happens and events wait in pending bits; loss occurs only via the collision rule above.
- Reset mid-operation: all state returns to reset values immediately; in-flight and pending events are discarded; re-arm as above.

Decomposition:
- Package btn_event_pkg:
  - ev_type_t enum (EV_PRESS = 2'b00, EV_LONG = 2'b01, EV_RELEASE = 2'b10).
  - ev_t packed struct {id, type}.
- Sub-module event_fifo: synchronous FWFT FIFO parameterised by width and depth, with full/empty outputs, in the same clk/reset.
- Edge detect, hold counters and the arbiter stay in btn_event_encoder.

Test Plan:
- Bench uses LONG_PRESS_CYC = 16.
- Single press: db_in = 4'b0001 for 5 cycles then 0, ev_ready = 1 -> press_pulse[0] for 1 cycle; events (0, press) then (0, release); no long event; overflow = 0.
- Simultaneous: db_in 0 -> 4'b0101 in one cycle -> (0, press) is presented one cycle before (2, press); both pulses in the same cycle.
- Long press: hold ch1 for 40 cycles -> exactly one (1, long), 15 cycles after the hold counter clears on rise; then (1, release) on release.
- Backpressure: ev_ready = 0, then 6 distinct events across 4 channels -> FIFO holds 4 and pending holds 2; overflow stays 0. A repeat event on a still-pending bit -> overflow = 1.
- Clear overflow: clear_overflow = 1 for one cycle -> overflow = 0.
- Reset behaviour:
  - db_in = 4'b1111 held through reset -> no press events after reset.
  - Assert reset while the FIFO holds 3 entries -> ev_valid = 0 the next cycle.

Source files
------------

// File: rtl/btn_event_pkg.sv
// Shared event encoding for the button event encoder and its FIFO.
package btn_event_pkg;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'b00,
        EV_LONG    = 2'b01,
        EV_RELEASE = 2'b10
    } ev_type_t;

    // Wide enough for up to 256 channels; the top only presents the low IDW bits.
    localparam int EV_ID_W = 8;

    typedef struct packed {
        logic [EV_ID_W-1:0] id;
        ev_type_t           typ;
    } ev_t;

    localparam int EV_W = $bits(ev_t);

    function automatic ev_t make_ev(input logic [EV_ID_W-1:0] id, input ev_type_t typ);
        ev_t e;
        e.id  = id;
        e.typ = typ;
        return e;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/btn_event_encoder.sv
// Turns debounced button levels into press/long/release pulses and a queued event
// stream, arbitrating one event per cycle into a small FIFO.
module btn_event_encoder
    import btn_event_pkg::*;
#(
    parameter int N              = 4,
    parameter int LONG_PRESS_CYC = 100_000_000,
    parameter int FIFO_DEPTH     = 4,
    parameter int IDW            = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   db_in,
    output logic [N-1:0]   press_pulse,
    output logic [N-1:0]   release_pulse,
    output logic           ev_valid,
    input  logic           ev_ready,
    output logic [IDW-1:0] ev_id,
    output logic [1:0]     ev_type,
    output logic           overflow,
    input  logic           clear_overflow
);

    localparam int            CW       = $clog2(LONG_PRESS_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(LONG_PRESS_CYC - 1);
    localparam logic [CW-1:0] CNT_FIRE = CW'(LONG_PRESS_CYC - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          r_armed;
    logic [N-1:0]  r_prev;
    logic [N-1:0]  r_track;
    logic [CW-1:0] r_cnt [N];
    logic [N-1:0]  r_pend_p;
    logic [N-1:0]  r_pend_l;
    logic [N-1:0]  r_pend_r;
    logic [N-1:0]  r_press_pulse;
    logic [N-1:0]  r_release_pulse;
    logic          r_overflow;

    logic [N-1:0]  w_rise;
    logic [N-1:0]  w_fall;
    logic [N-1:0]  w_long;
    logic [N-1:0]  w_clr_p;
    logic [N-1:0]  w_clr_l;
    logic [N-1:0]  w_clr_r;
    logic          w_push;
    ev_t           w_push_ev;
    ev_t           w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic          w_unused_id;

    // Until armed, the first sample only seeds r_prev so levels held through reset stay silent.
    assign w_rise = r_armed ? (db_in & ~r_prev) : '0;
    assign w_fall = r_armed ? (~db_in & r_prev) : '0;

    always_comb begin
        w_long = '0;
        for (int i = 0; i < N; i++) begin
            w_long[i] = r_armed && db_in[i] && r_track[i] && (r_cnt[i] == CNT_FIRE);
        end
    end

    // Lowest channel first; within a channel press beats long beats release.
    always_comb begin
        logic found;
        found     = 1'b0;
        w_push    = 1'b0;
        w_push_ev = make_ev('0, EV_PRESS);
        w_clr_p   = '0;
        w_clr_l   = '0;
        w_clr_r   = '0;
        if (!w_full) begin
            for (int i = 0; i < N; i++) begin
                if (!found && (r_pend_p[i] || r_pend_l[i] || r_pend_r[i])) begin
                    found  = 1'b1;
                    w_push = 1'b1;
                    if (r_pend_p[i]) begin
                        w_push_ev  = make_ev(EV_ID_W'(i), EV_PRESS);
                        w_clr_p[i] = 1'b1;
                    end else if (r_pend_l[i]) begin
                        w_push_ev  = make_ev(EV_ID_W'(i), EV_LONG);
                        w_clr_l[i] = 1'b1;
                    end else begin
                        w_push_ev  = make_ev(EV_ID_W'(i), EV_RELEASE);
                        w_clr_r[i] = 1'b1;
                    end
                end
            end
        end
    end

    // A new event only collides if its bit stays pending after this cycle's push.
    assign w_drop = |((w_rise & r_pend_p & ~w_clr_p) |
                      (w_long & r_pend_l & ~w_clr_l) |
                      (w_fall & r_pend_r & ~w_clr_r));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed         <= 1'b0;
            r_prev          <= '0;
            r_press_pulse   <= '0;
            r_release_pulse <= '0;
            r_pend_p        <= '0;
            r_pend_l        <= '0;
            r_pend_r        <= '0;
            r_overflow      <= 1'b0;
        end else begin
            r_armed         <= 1'b1;
            r_prev          <= db_in;
            r_press_pulse   <= w_rise;
            r_release_pulse <= w_fall;
            r_pend_p        <= (r_pend_p & ~w_clr_p) | w_rise;
            r_pend_l        <= (r_pend_l & ~w_clr_l) | w_long;
            r_pend_r        <= (r_pend_r & ~w_clr_r) | w_fall;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Hold counters only run for presses seen while armed and saturate at the threshold.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset || !r_armed || !db_in[i]) begin
                r_cnt[i]   <= '0;
                r_track[i] <= 1'b0;
            end else if (w_rise[i]) begin
                r_cnt[i]   <= '0;
                r_track[i] <= 1'b1;
            end else if (r_track[i] && (r_cnt[i] != CNT_LAST)) begin
                r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end
        end
    end

    event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_ev),
        .i_pop   (ev_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Handshake: the head event is offered while ev_valid is high and holds steady
    // until the consumer raises ev_ready; the pop happens on the edge where both are high.
    assign ev_valid      = !w_empty;
    assign ev_id         = w_head.id[IDW-1:0];
    assign ev_type       = w_head.typ;
    assign w_unused_id   = ^w_head.id;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_btn_event_encoder.sv
// Directed bench for btn_event_encoder with a short long-press threshold.
module tb_btn_event_encoder;

    localparam int         N  = 4;
    localparam int         LP = 16;
    localparam int         FD = 4;
    localparam logic [1:0] T_P = 2'b00;
    localparam logic [1:0] T_L = 2'b01;
    localparam logic [1:0] T_R = 2'b10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] db_in = '0;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic         ev_valid;
    logic         ev_ready = 1'b0;
    logic [1:0]   ev_id;
    logic [1:0]   ev_type;
    logic         overflow;
    logic         clear_overflow = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    int         obs_t[$];

    btn_event_encoder #(
        .N              (N),
        .LONG_PRESS_CYC (LP),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .db_in          (db_in),
        .press_pulse    (press_pulse),
        .release_pulse  (release_pulse),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_id          (ev_id),
        .ev_type        (ev_type),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    // Clock, cycle counter and watchdog
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Records every accepted event; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            obs_q.push_back({ev_id, ev_type});
            obs_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
    endtask

    task automatic test_reset();
        db_in = '0; ev_ready = 1'b0; clear_overflow = 1'b0; reset = 1'b1;
        tick(); tick();
        checks++;
        if ({press_pulse, release_pulse} !== 8'h00) begin
            errors++; $display("FAIL reset_pulses: got %b, expected 00000000", {press_pulse, release_pulse});
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b, expected 0", ev_valid);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %b, expected 0", overflow);
        end
        checks++;
        if ({ev_id, ev_type} !== 4'h0) begin
            errors++; $display("FAIL reset_head: got %h, expected 0", {ev_id, ev_type});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_press();
        clear_queues();
        ev_ready = 1'b1;
        db_in = 4'b0001;
        tick();
        checks++;
        if (press_pulse !== 4'b0001) begin
            errors++; $display("FAIL single_press_pulse: got %b, expected 0001", press_pulse);
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL single_valid_early: got %b, expected 0", ev_valid);
        end
        tick();
        checks++;
        if (press_pulse !== 4'b0000) begin
            errors++; $display("FAIL single_pulse_width: got %b, expected 0000", press_pulse);
        end
        checks++;
        if ({ev_valid, ev_id, ev_type} !== {1'b1, 2'd0, T_P}) begin
            errors++; $display("FAIL single_latency: got %b, expected %b", {ev_valid, ev_id, ev_type}, {1'b1, 2'd0, T_P});
        end
        tick(); tick(); tick();
        db_in = 4'b0000;
        tick();
        checks++;
        if (release_pulse !== 4'b0001) begin
            errors++; $display("FAIL single_release_pulse: got %b, expected 0001", release_pulse);
        end
        repeat (6) tick();
        exp_q.push_back({2'd0, T_P});
        exp_q.push_back({2'd0, T_R});
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL single_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL single_event[%0d]: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : 4'hx, exp_q[i]);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL single_overflow: got %b, expected 0", overflow);
        end
    endtask

    task automatic test_simultaneous();
        clear_queues();
        ev_ready = 1'b1;
        db_in = 4'b0101;
        tick();
        checks++;
        if (press_pulse !== 4'b0101) begin
            errors++; $display("FAIL simul_pulses: got %b, expected 0101", press_pulse);
        end
        tick();
        checks++;
        if ({ev_valid, ev_id, ev_type} !== {1'b1, 2'd0, T_P}) begin
            errors++; $display("FAIL simul_first: got %b, expected %b", {ev_valid, ev_id, ev_type}, {1'b1, 2'd0, T_P});
        end
        tick();
        checks++;
        if ({ev_valid, ev_id, ev_type} !== {1'b1, 2'd2, T_P}) begin
            errors++; $display("FAIL simul_second: got %b, expected %b", {ev_valid, ev_id, ev_type}, {1'b1, 2'd2, T_P});
        end
        tick();
        db_in = 4'b0000;
        repeat (7) tick();
        exp_q.push_back({2'd0, T_P});
        exp_q.push_back({2'd2, T_P});
        exp_q.push_back({2'd0, T_R});
        exp_q.push_back({2'd2, T_R});
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL simul_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL simul_event[%0d]: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : 4'hx, exp_q[i]);
            end
        end
        checks++;
        if (obs_t.size() < 2 || (obs_t[1] - obs_t[0]) !== 1) begin
            errors++; $display("FAIL simul_spacing: got %0d cycles, expected 1", (obs_t.size() < 2) ? -1 : obs_t[1] - obs_t[0]);
        end
    endtask

    task automatic test_long_press();
        clear_queues();
        ev_ready = 1'b1;
        db_in = 4'b0010;
        repeat (40) tick();
        db_in = 4'b0000;
        repeat (6) tick();
        exp_q.push_back({2'd1, T_P});
        exp_q.push_back({2'd1, T_L});
        exp_q.push_back({2'd1, T_R});
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL long_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL long_event[%0d]: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : 4'hx, exp_q[i]);
            end
        end
        checks++;
        if (obs_t.size() < 2 || (obs_t[1] - obs_t[0]) !== LP - 1) begin
            errors++; $display("FAIL long_delay: got %0d cycles, expected %0d", (obs_t.size() < 2) ? -1 : obs_t[1] - obs_t[0], LP - 1);
        end
    endtask

    task automatic test_backpressure();
        clear_queues();
        ev_ready = 1'b0;
        db_in = 4'b1111;
        tick();
        repeat (4) tick();
        checks++;
        if ({ev_valid, ev_id, ev_type} !== {1'b1, 2'd0, T_P}) begin
            errors++; $display("FAIL bp_head_full: got %b, expected %b", {ev_valid, ev_id, ev_type}, {1'b1, 2'd0, T_P});
        end
        db_in = 4'b1100;
        tick();
        checks++;
        if (release_pulse !== 4'b0011) begin
            errors++; $display("FAIL bp_release_pulse: got %b, expected 0011", release_pulse);
        end
        tick(); tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL bp_no_overflow: got %b, expected 0", overflow);
        end
        db_in = 4'b1101;
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL bp_repress_no_overflow: got %b, expected 0", overflow);
        end
        db_in = 4'b1100;
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL bp_overflow_set: got %b, expected 1", overflow);
        end
        checks++;
        if ({ev_valid, ev_id, ev_type} !== {1'b1, 2'd0, T_P}) begin
            errors++; $display("FAIL bp_head_stable: got %b, expected %b", {ev_valid, ev_id, ev_type}, {1'b1, 2'd0, T_P});
        end
        ev_ready = 1'b1;
        db_in = 4'b0000;
        repeat (12) tick();
        exp_q.push_back({2'd0, T_P});
        exp_q.push_back({2'd1, T_P});
        exp_q.push_back({2'd2, T_P});
        exp_q.push_back({2'd3, T_P});
        exp_q.push_back({2'd0, T_P});
        exp_q.push_back({2'd0, T_R});
        exp_q.push_back({2'd1, T_R});
        exp_q.push_back({2'd2, T_R});
        exp_q.push_back({2'd3, T_R});
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL bp_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_event[%0d]: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : 4'hx, exp_q[i]);
            end
        end
        checks++;
        if ({ev_valid, overflow} !== 2'b01) begin
            errors++; $display("FAIL bp_drained_sticky: got valid/overflow %b, expected 01", {ev_valid, overflow});
        end
    endtask

    task automatic test_clear_overflow();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL clear_overflow: got %b, expected 0", overflow);
        end
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL clear_overflow_hold: got %b, expected 0", overflow);
        end
    endtask

    task automatic test_reset_held();
        logic [N-1:0] seen;
        seen = '0;
        db_in = 4'b1111;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        clear_queues();
        ev_ready = 1'b1;
        repeat (20) begin
            tick();
            seen = seen | press_pulse;
        end
        checks++;
        if (seen !== 4'b0000) begin
            errors++; $display("FAIL held_press_pulse: got %b, expected 0000", seen);
        end
        checks++;
        if (obs_q.size() !== 0) begin
            errors++; $display("FAIL held_events: got %0d events, expected 0", obs_q.size());
        end
    endtask

    task automatic test_reset_flush();
        ev_ready = 1'b0;
        db_in = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        db_in = 4'b0111;
        tick();
        repeat (3) tick();
        checks++;
        if ({ev_valid, ev_id, ev_type} !== {1'b1, 2'd0, T_P}) begin
            errors++; $display("FAIL flush_loaded: got %b, expected %b", {ev_valid, ev_id, ev_type}, {1'b1, 2'd0, T_P});
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({ev_valid, ev_id, ev_type, press_pulse} !== 9'h000) begin
            errors++; $display("FAIL flush_cleared: got %b, expected 000000000", {ev_valid, ev_id, ev_type, press_pulse});
        end
        reset = 1'b0;
        tick();
        clear_queues();
        ev_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (obs_q.size() !== 0) begin
            errors++; $display("FAIL flush_stale: got %0d events, expected 0", obs_q.size());
        end
        db_in = 4'b0000;
        repeat (6) tick();
        exp_q.push_back({2'd0, T_R});
        exp_q.push_back({2'd1, T_R});
        exp_q.push_back({2'd2, T_R});
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL flush_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL flush_event[%0d]: got %h, expected %h", i, (i < obs_q.size()) ? obs_q[i] : 4'hx, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_long_press();
        test_backpressure();
        test_clear_overflow();
        test_reset_held();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
